key_lock_ctrl: RTL and testbench
================================

// Module: key_lock_ctrl
// PURPOSE
//  4-digit code-lock controller for the 4x4 matrix keypad scanner. Consumes the
//  scanner's debounced key_flag/key_data (generated in its 1 kHz domain), edits a
//  4-digit entry, checks it against a stored code, drives unlock/alarm, and
//  supports a code change. Entry digits go to the 7-seg display driver.
// PARAMETERS
//  TICK_DIV   50000     clk cycles per 1 ms timer tick (50 MHz clk)
//  UNLOCK_MS  5000      open-window length in ms; restarts on each accepted key
//  LOCK_MS    10000     lockout length in ms after MAX_FAIL bad codes
//  MAX_FAIL   3         consecutive wrong entries that trigger lockout
//  INIT_CODE  16'h1234  code after reset, 4 BCD nibbles, MSN = first digit
// PORTS
//  clk        in   1   system clock, 50 MHz
//  rst_n      in   1   asynchronous reset, active low
//  key_flag   in   1   scanner key-valid level (asynchronous to clk, held >=1 ms)
//  key_data   in   4   scanner key value 0..15, stable while key_flag high
//  disp_data  out  16  entry digits, newest digit in [3:0]
//  disp_mask  out  4   digit-valid bits, bit0 = newest digit
//  unlock     out  1   lock open (OPEN and NEW_CODE states)
//  alarm      out  1   high during LOCKOUT
//  err        out  1   1-cycle pulse on a rejected Enter
// BEHAVIOUR
//  Reset: state LOCKED; disp_data 0, disp_mask 0, unlock 0, alarm 0, err 0,
//   code INIT_CODE, fail count 0, timers 0. Reset mid-op restores INIT_CODE.
//  Key event: key_flag -> 2-flop sync -> rising-edge detect = 1-cycle evt;
//   key_data taken at evt. Outputs update on the 3rd clk edge after key_flag
//   rises. One evt per key press; key_flag low clears nothing.
//  Keys: 0-9 digit; 10(A) Enter; 11(b) Backspace; 12(C) Clear; 13(d) Change; 14,15 ignored.
//  Entry edit (LOCKED, NEW_CODE):
//   - digit with mask!=4'hF: data<={data[11:0],d}, mask<={mask[2:0],1}; mask full: dropped
//   - Backspace: data<={4'h0,data[15:4]}, mask<=mask>>1 (no-op if empty)
//   - Clear: data<=0, mask<=0
//  LOCKED:
//   - Enter, mask==F and data==code: -> OPEN, unlock=1, fail=0, entry cleared
//   - Enter otherwise: err pulse, fail+1, entry cleared; if fail+1==MAX_FAIL:
//     -> LOCKOUT, alarm=1, fail=0. Change key ignored.
//  OPEN: unlock=1; ms timer runs; any accepted key restarts it.
//   - Clear or timer==UNLOCK_MS: -> LOCKED, unlock=0
//   - Change: -> NEW_CODE, entry cleared; other keys ignored
//  NEW_CODE: unlock=1; same timer rules; entry edit active.
//   - Enter with mask==F: code<=data, entry cleared, -> OPEN (timer restart)
//   - Enter with mask!=F: err pulse, stay, entry kept; fail count untouched
//   - Clear with mask!=0: clear entry; Clear with mask==0: -> OPEN, code unchanged
//   - timeout: -> LOCKED, code unchanged, entry cleared
//  LOCKOUT: alarm=1, all keys ignored; after LOCK_MS ms -> LOCKED, alarm=0.
//  Timers: prescaler 0..TICK_DIV-1 gives 1 ms tick; 16-bit ms counter, cleared
//   on state entry. Timeout and key evt in the same cycle: timeout wins, key dropped.
//  Digits are not range-checked beyond key codes; code compare is 16-bit equality.
// TESTING (TICK_DIV=10, UNLOCK_MS=5, LOCK_MS=8, key_flag held 20 cycles per press)
//  1 Reset, keys 1,2,3,4,A -> disp_data 0x1234/mask F before A; after A unlock=1,
//    entry 0; unlock drops to 0 exactly 50 clk (5 ticks) after last key.
//  2 Keys 1,2,3,5,A three times -> err pulse each time; 3rd -> alarm=1 for 80 clk,
//    keys during lockout have no effect; then LOCKED.
//  3 Keys 9,8,7,6,5 -> data 0x9876 (5 dropped); b -> 0x0987/mask 7; C -> 0/0.
//  4 Unlock, d, 4,3,2,1,A, C -> LOCKED; 1,2,3,4,A -> err; 4,3,2,1,A -> unlock.
//  5 NEW_CODE, keys 5,5,A -> err, stays NEW_CODE, unlock=1, data 0x0055.
//  6 Assert rst_n=0 mid-entry after code change -> all outputs 0; 1,2,3,4,A opens.

Source files
------------

// File: rtl/key_lock_ctrl.sv
// key_lock_ctrl: 4-digit code lock driven by the keypad scanner.
// Synchronises the scanner key flag, edits a 4-digit entry, checks it against
// the stored code, and drives unlock/alarm/err plus the entry display.
module key_lock_ctrl #(
  parameter int unsigned        TICK_DIV  = 50000,
  parameter int unsigned        UNLOCK_MS = 5000,
  parameter int unsigned        LOCK_MS   = 10000,
  parameter int unsigned        MAX_FAIL  = 3,
  parameter logic        [15:0] INIT_CODE = 16'h1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_flag,
  input  logic [3:0]  key_data,
  output logic [15:0] disp_data,
  output logic [3:0]  disp_mask,
  output logic        unlock,
  output logic        alarm,
  output logic        err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [3:0] K_ENTER  = 4'd10;
  localparam logic [3:0] K_BKSP   = 4'd11;
  localparam logic [3:0] K_CLEAR  = 4'd12;
  localparam logic [3:0] K_CHANGE = 4'd13;

  typedef enum logic [1:0] {
    S_LOCKED,
    S_OPEN,
    S_NEW_CODE,
    S_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync_q;
  logic [15:0]     data_q, data_d;
  logic [3:0]      mask_q, mask_d;
  logic [15:0]     code_q, code_d;
  logic [FW-1:0]   fail_q, fail_d, fail_inc;
  logic            err_q, err_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     ms_q, ms_d, ms_lim;
  logic            evt, tick, timeout, restart, timer_clr;
  logic            is_digit;
  logic [15:0]     edit_data;
  logic [3:0]      edit_mask;

  assign evt      = sync_q[1] & ~sync_q[2];
  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign ms_lim   = (state_q == S_LOCKOUT) ? 16'(LOCK_MS - 1) : 16'(UNLOCK_MS - 1);
  // Terminal count is reached on the tick that would make ms equal the limit,
  // so the state leaves exactly limit*TICK_DIV cycles after the timer cleared.
  assign timeout  = tick && (ms_q == ms_lim) && (state_q != S_LOCKED);
  assign is_digit = (key_data <= 4'd9);
  assign fail_inc = fail_q + 1'b1;

  assign disp_data = data_q;
  assign disp_mask = mask_q;
  assign unlock    = (state_q == S_OPEN) || (state_q == S_NEW_CODE);
  assign alarm     = (state_q == S_LOCKOUT);
  assign err       = err_q;

  // Key-flag synchroniser and rising-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], key_flag};
  end

  // Entry edit result for digit / backspace / clear keys
  always_comb begin
    edit_data = data_q;
    edit_mask = mask_q;
    if (is_digit) begin
      if (mask_q != 4'hF) begin
        edit_data = {data_q[11:0], key_data};
        edit_mask = {mask_q[2:0], 1'b1};
      end
    end else if (key_data == K_BKSP) begin
      edit_data = {4'h0, data_q[15:4]};
      edit_mask = mask_q >> 1;
    end else if (key_data == K_CLEAR) begin
      edit_data = '0;
      edit_mask = '0;
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    code_d  = code_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      S_LOCKED: begin
        if (evt) begin
          if (is_digit || key_data == K_BKSP || key_data == K_CLEAR) begin
            data_d = edit_data;
            mask_d = edit_mask;
          end else if (key_data == K_ENTER) begin
            data_d = '0;
            mask_d = '0;
            if (mask_q == 4'hF && data_q == code_q) begin
              state_d = S_OPEN;
              fail_d  = '0;
            end else begin
              err_d = 1'b1;
              if (fail_inc == FW'(MAX_FAIL)) begin
                state_d = S_LOCKOUT;
                fail_d  = '0;
              end else begin
                fail_d = fail_inc;
              end
            end
          end
        end
      end
      S_OPEN: begin
        if (timeout) begin
          state_d = S_LOCKED;
        end else if (evt) begin
          restart = 1'b1;
          if (key_data == K_CLEAR) begin
            state_d = S_LOCKED;
          end else if (key_data == K_CHANGE) begin
            state_d = S_NEW_CODE;
            data_d  = '0;
            mask_d  = '0;
          end
        end
      end
      S_NEW_CODE: begin
        if (timeout) begin
          state_d = S_LOCKED;
          data_d  = '0;
          mask_d  = '0;
        end else if (evt) begin
          restart = 1'b1;
          if (is_digit || key_data == K_BKSP) begin
            data_d = edit_data;
            mask_d = edit_mask;
          end else if (key_data == K_CLEAR) begin
            if (mask_q == '0) state_d = S_OPEN;
            data_d = '0;
            mask_d = '0;
          end else if (key_data == K_ENTER) begin
            if (mask_q == 4'hF) begin
              code_d  = data_q;
              data_d  = '0;
              mask_d  = '0;
              state_d = S_OPEN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_LOCKOUT: begin
        if (timeout) state_d = S_LOCKED;
      end
      default: state_d = S_LOCKED;
    endcase
  end

  // Millisecond timer restarts on state entry and on accepted keys
  always_comb begin
    timer_clr = restart || (state_d != state_q);
    if (timer_clr) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (tick) begin
      presc_d = '0;
      ms_d    = ms_q + 16'd1;
    end else begin
      presc_d = presc_q + 1'b1;
      ms_d    = ms_q;
    end
  end

  // State, entry, code, fail count and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      data_q  <= '0;
      mask_q  <= '0;
      code_q  <= INIT_CODE;
      fail_q  <= '0;
      err_q   <= 1'b0;
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

endmodule

// File: tb/tb_key_lock_ctrl.sv
// tb_key_lock_ctrl: directed test of key_lock_ctrl with short timer settings.
module tb_key_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_flag;
  logic [3:0]  key_data;
  logic [15:0] disp_data;
  logic [3:0]  disp_mask;
  logic        unlock;
  logic        alarm;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int alarm_cnt = 0;
  int err_base;
  int alarm_base;

  key_lock_ctrl #(
    .TICK_DIV (10),
    .UNLOCK_MS(5),
    .LOCK_MS  (8),
    .MAX_FAIL (3),
    .INIT_CODE(16'h1234)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_flag (key_flag),
    .key_data (key_data),
    .disp_data(disp_data),
    .disp_mask(disp_mask),
    .unlock   (unlock),
    .alarm    (alarm),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Count err pulse cycles and alarm-high cycles
  always @(negedge clk) begin
    if (rst_n && err)   err_cnt++;
    if (rst_n && alarm) alarm_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_data = k;
    key_flag = 1'b1;
    repeat (20) @(negedge clk);
    key_flag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic enter4(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    press(v[15:12]);
    press(v[11:8]);
    press(v[7:4]);
    press(v[3:0]);
  endtask

  initial begin
    rst_n    = 1'b0;
    key_flag = 1'b0;
    key_data = 4'h0;
    repeat (3) @(negedge clk);
    check_val("rst_data", disp_data, 16'h0);
    check_val("rst_mask", disp_mask, 4'h0);
    check_val("rst_unlock", unlock, 1'b0);
    check_val("rst_alarm", alarm, 1'b0);
    check_val("rst_err", err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: correct code opens, window is 50 clk after last key
    enter4(16'h1234);
    check_val("t1_data", disp_data, 16'h1234);
    check_val("t1_mask", disp_mask, 4'hF);
    check_val("t1_locked", unlock, 1'b0);
    @(negedge clk);
    key_data = 4'd10;
    key_flag = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_val("t1_pre_evt", unlock, 1'b0);
    @(posedge clk);
    #1 check_val("t1_open", unlock, 1'b1);
    check_val("t1_clr_data", disp_data, 16'h0);
    check_val("t1_clr_mask", disp_mask, 4'h0);
    for (int i = 1; i <= 49; i++) begin
      @(posedge clk);
      #1;
      if (i == 17) key_flag = 1'b0;
    end
    check_val("t1_open_49", unlock, 1'b1);
    @(posedge clk);
    #1 check_val("t1_closed_50", unlock, 1'b0);
    repeat (5) @(negedge clk);

    // 2: three bad codes -> lockout for 80 clk, keys ignored meanwhile
    err_base = err_cnt;
    enter4(16'h1235); press(4'd10);
    check_val("t2_err1", err_cnt - err_base, 1);
    check_val("t2_no_alarm", alarm, 1'b0);
    enter4(16'h1235); press(4'd10);
    check_val("t2_err2", err_cnt - err_base, 2);
    alarm_base = alarm_cnt;
    enter4(16'h1235); press(4'd10);
    check_val("t2_err3", err_cnt - err_base, 3);
    check_val("t2_alarm", alarm, 1'b1);
    press(4'd7);
    check_val("t2_ign_data", disp_data, 16'h0);
    check_val("t2_ign_mask", disp_mask, 4'h0);
    check_val("t2_alarm_held", alarm, 1'b1);
    repeat (40) @(negedge clk);
    check_val("t2_alarm_off", alarm, 1'b0);
    check_val("t2_alarm_len", alarm_cnt - alarm_base, 80);
    check_val("t2_unlock", unlock, 1'b0);

    // 3: overflow digit dropped, backspace, clear
    enter4(16'h9876); press(4'd5);
    check_val("t3_data", disp_data, 16'h9876);
    check_val("t3_mask", disp_mask, 4'hF);
    press(4'd11);
    check_val("t3_bs_data", disp_data, 16'h0987);
    check_val("t3_bs_mask", disp_mask, 4'h7);
    press(4'd12);
    check_val("t3_clr_data", disp_data, 16'h0);
    check_val("t3_clr_mask", disp_mask, 4'h0);

    // 4: change code to 4321
    enter4(16'h1234); press(4'd10);
    check_val("t4_open", unlock, 1'b1);
    press(4'd13);
    check_val("t4_newcode", unlock, 1'b1);
    enter4(16'h4321);
    check_val("t4_nc_data", disp_data, 16'h4321);
    press(4'd10);
    check_val("t4_nc_done", disp_data, 16'h0);
    check_val("t4_nc_open", unlock, 1'b1);
    press(4'd12);
    check_val("t4_relock", unlock, 1'b0);
    err_base = err_cnt;
    enter4(16'h1234); press(4'd10);
    check_val("t4_old_err", err_cnt - err_base, 1);
    check_val("t4_old_locked", unlock, 1'b0);
    enter4(16'h4321); press(4'd10);
    check_val("t4_new_open", unlock, 1'b1);

    // 5: short entry in NEW_CODE is rejected, entry kept; then timeout
    press(4'd13);
    err_base = err_cnt;
    press(4'd5); press(4'd5); press(4'd10);
    check_val("t5_err", err_cnt - err_base, 1);
    check_val("t5_unlock", unlock, 1'b1);
    check_val("t5_data", disp_data, 16'h0055);
    check_val("t5_mask", disp_mask, 4'h3);
    repeat (60) @(negedge clk);
    check_val("t5_timeout", unlock, 1'b0);
    check_val("t5_to_data", disp_data, 16'h0);

    // 6: reset mid-entry restores initial code
    press(4'd7);
    check_val("t6_pre_data", disp_data, 16'h0007);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_data", disp_data, 16'h0);
    check_val("t6_rst_mask", disp_mask, 4'h0);
    check_val("t6_rst_unlock", unlock, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    err_base = err_cnt;
    enter4(16'h4321); press(4'd10);
    check_val("t6_old_err", err_cnt - err_base, 1);
    enter4(16'h1234); press(4'd10);
    check_val("t6_open", unlock, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
